// File: rtl/spi_slave_read_tx_if.sv
// Read-path bundle between the SPI slave transmitter and its slave FSM / register file.
interface spi_slave_read_tx_if #(
    parameter int WIDTH = 8
);
    logic             SS;
    logic             Rd_req;
    logic             Burst;
    logic [WIDTH-1:0] Address;
    logic [WIDTH-1:0] Rd_Data;
    logic             Rd_Valid;
    logic             Rd_EN;
    logic [WIDTH-1:0] Rd_Addr;
    logic             MISO;
    logic             MISO_OE;
    logic             tx_tick;

    modport slave (
        input  SS, Rd_req, Burst, Address, Rd_Data, Rd_Valid,
        output Rd_EN, Rd_Addr, MISO, MISO_OE, tx_tick
    );

    modport master (
        output SS, Rd_req, Burst, Address, Rd_Data, Rd_Valid,
        input  Rd_EN, Rd_Addr, MISO, MISO_OE, tx_tick
    );
endinterface

// File: rtl/spi_slave_read_tx.sv
// SPI read transmitter: fetch a word from the register file, shift it MSB first (optional parity via SPI_TX_PARITY_EN).
// First bit 3+ SCLK after Rd_req; waits indefinitely on Rd_Valid; SS high aborts asynchronously.
module spi_slave_read_tx #(
    parameter int WIDTH = 8
) (
    input  logic                SCLK,
    input  logic                RST,
    spi_slave_read_tx_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SHIFT
`ifdef SPI_TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    bit_cnt, bit_cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] rd_addr, rd_addr_n;
    logic             rd_en, rd_en_n;
    logic             miso, miso_n;
    logic             miso_oe, miso_oe_n;
    logic             tx_tick, tx_tick_n;
    logic             word_end;
    logic             ss;
    logic             last;
`ifdef SPI_TX_PARITY_EN
    logic             par, par_n;
`endif

    assign ss   = bus.SS;
    assign last = (bit_cnt == LAST);

    // SS clears the control path asynchronously; address and data survive an abort.
    always_ff @(posedge SCLK or negedge RST or posedge ss) begin
        if (!RST) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            rd_en   <= 1'b0;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
            tx_tick <= 1'b0;
        end else if (ss) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            rd_en   <= 1'b0;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
            tx_tick <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            rd_en   <= rd_en_n;
            miso    <= miso_n;
            miso_oe <= miso_oe_n;
            tx_tick <= tx_tick_n;
        end
    end

    always_ff @(posedge SCLK or negedge RST) begin
        if (!RST) begin
            rd_addr <= '0;
            shreg   <= '0;
`ifdef SPI_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else if (!ss) begin
            rd_addr <= rd_addr_n;
            shreg   <= shreg_n;
`ifdef SPI_TX_PARITY_EN
            par     <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (bus.Rd_req)   state_n = S_FETCH;
            S_FETCH:                   state_n = S_WAIT;
            S_WAIT:  if (bus.Rd_Valid) state_n = S_SHIFT;
            S_SHIFT: begin
                if (last) begin
`ifdef SPI_TX_PARITY_EN
                    state_n = S_PARITY;
`else
                    state_n = bus.Burst ? S_FETCH : S_IDLE;
`endif
                end
            end
`ifdef SPI_TX_PARITY_EN
            S_PARITY: state_n = bus.Burst ? S_FETCH : S_IDLE;
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en_n   = 1'b0;
        tx_tick_n = 1'b0;
        miso_n    = miso;
        miso_oe_n = miso_oe;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        rd_addr_n = rd_addr;
        word_end  = 1'b0;
`ifdef SPI_TX_PARITY_EN
        par_n     = par;
`endif
        case (state)
            S_IDLE: begin
                if (bus.Rd_req) begin
                    rd_addr_n = bus.Address;
                    rd_en_n   = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.Rd_Valid) begin
                    shreg_n   = bus.Rd_Data;
                    miso_n    = bus.Rd_Data[WIDTH-1];
                    miso_oe_n = 1'b1;
                    bit_cnt_n = '0;
`ifdef SPI_TX_PARITY_EN
                    par_n     = ~^bus.Rd_Data;
`endif
                end
            end
            S_SHIFT: begin
                if (!last) begin
                    // Rotate so the bit on the line is always the MSB of shreg.
                    shreg_n   = {shreg[WIDTH-2:0], shreg[WIDTH-1]};
                    miso_n    = shreg[WIDTH-2];
                    bit_cnt_n = bit_cnt + CW'(1);
                end else begin
`ifdef SPI_TX_PARITY_EN
                    miso_n   = par;
`else
                    word_end = 1'b1;
`endif
                end
            end
`ifdef SPI_TX_PARITY_EN
            S_PARITY: word_end = 1'b1;
`endif
            default: ;
        endcase

        if (word_end) begin
            tx_tick_n = 1'b1;
            miso_oe_n = 1'b0;
            if (bus.Burst) begin
                rd_addr_n = rd_addr + WIDTH'(1);
                rd_en_n   = 1'b1;
            end else begin
                miso_n = 1'b0;
            end
        end
    end

    assign bus.Rd_EN   = rd_en;
    assign bus.Rd_Addr = rd_addr;
    assign bus.MISO    = miso;
    assign bus.MISO_OE = miso_oe;
    assign bus.tx_tick = tx_tick;
endmodule

// File: tb/tb_spi_slave_read_tx.sv
// Self-checking bench for spi_slave_read_tx (WIDTH=8): directed table, corner sequences, randomized reads.
module tb_spi_slave_read_tx;
    logic SCLK = 1'b0;
    logic RST  = 1'b0;

    spi_slave_read_tx_if #(.WIDTH(8)) bus ();
    spi_slave_read_tx #(.WIDTH(8)) dut (.SCLK(SCLK), .RST(RST), .bus(bus));

    always #5 SCLK = ~SCLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0]      addr;
        logic [1:0]      nw;
        logic [2:0]      dly;
        logic [2:0][7:0] d;
        logic [2:0][7:0] ea;
    } vec_t;

    vec_t vecs [4];

    // One read (optionally a burst): the bench plays register file and captures MISO.
    task automatic xfer(input string tag, input logic [7:0] addr, input int nw, input int dly,
                        input logic [2:0][7:0] d, input logic [2:0][7:0] ea, input bit noise);
        logic [7:0] got;
        bit         oe_ok;
        @(negedge SCLK);
        bus.Address = addr;
        bus.Rd_req  = 1'b1;
        bus.Burst   = (nw > 1);
        @(negedge SCLK);
        bus.Rd_req  = 1'b0;
        for (int w = 0; w < nw; w++) begin
            chk({tag, " rd_en"}, 32'(bus.Rd_EN), 32'd1);
            chk({tag, " rd_addr"}, 32'(bus.Rd_Addr), 32'(ea[w]));
            for (int k = 0; k <= dly; k++) begin
                @(negedge SCLK);
                chk({tag, " wait"}, 32'({bus.Rd_EN, bus.MISO_OE}), 32'd0);
            end
            bus.Rd_Valid = 1'b1;
            bus.Rd_Data  = d[w];
            bus.Burst    = (w < nw - 1);
            got   = '0;
            oe_ok = 1'b1;
            for (int b = 0; b < 8; b++) begin
                @(negedge SCLK);
                bus.Rd_Valid = 1'b0;
                bus.Rd_Data  = 8'($urandom);
                if (noise) begin
                    bus.Rd_req  = 1'($urandom);
                    bus.Address = 8'($urandom);
                end
                got = {got[6:0], bus.MISO};
                if (bus.MISO_OE !== 1'b1 || bus.tx_tick !== 1'b0) oe_ok = 1'b0;
            end
            chk({tag, " word"}, 32'(got), 32'(d[w]));
            chk({tag, " oe_during_word"}, 32'(oe_ok), 32'd1);
`ifdef SPI_TX_PARITY_EN
            @(negedge SCLK);
            chk({tag, " parity"}, 32'({bus.MISO_OE, bus.tx_tick, bus.MISO}), 32'({2'b10, ~^d[w]}));
`endif
            @(negedge SCLK);
            bus.Rd_req = 1'b0;
            chk({tag, " tick"}, 32'({bus.tx_tick, bus.MISO_OE}), 32'b10);
        end
        chk({tag, " end_idle"}, 32'({bus.Rd_EN, bus.MISO}), 32'd0);
        @(negedge SCLK);
        chk({tag, " tick_pulse"}, 32'(bus.tx_tick), 32'd0);
    endtask

    initial begin
        logic [7:0]      ra;
        int              rn, rdly;
        logic [2:0][7:0] rd, rea;
        logic [3:0]      first4;

        bus.SS = 1'b0; bus.Rd_req = 1'b0; bus.Burst = 1'b0;
        bus.Address = '0; bus.Rd_Data = '0; bus.Rd_Valid = 1'b0;

        vecs[0] = '{8'h3C, 2'd1, 3'd0, {8'h00, 8'h00, 8'hA5}, {8'h00, 8'h00, 8'h3C}};
        vecs[1] = '{8'hFE, 2'd3, 3'd0, {8'h33, 8'h22, 8'h11}, {8'h00, 8'hFF, 8'hFE}};
        vecs[2] = '{8'h81, 2'd1, 3'd5, {8'h00, 8'h00, 8'h4E}, {8'h00, 8'h00, 8'h81}};
        vecs[3] = '{8'h07, 2'd2, 3'd2, {8'h00, 8'hFF, 8'h00}, {8'h00, 8'h08, 8'h07}};

        #1;
        chk("reset_outputs", 32'({bus.Rd_EN, bus.Rd_Addr, bus.MISO, bus.MISO_OE, bus.tx_tick}), 32'd0);
        @(negedge SCLK);
        RST = 1'b1;
        @(negedge SCLK);
        chk("idle_after_reset", 32'({bus.Rd_EN, bus.MISO_OE, bus.tx_tick}), 32'd0);

        for (int i = 0; i < 4; i++)
            xfer($sformatf("vec%0d", i), vecs[i].addr, int'(vecs[i].nw), int'(vecs[i].dly),
                 vecs[i].d, vecs[i].ea, 1'b0);

        // Abort after four bits of 0xF0: the line is still high, so clearing is visible.
        @(negedge SCLK);
        bus.Address = 8'h55; bus.Rd_req = 1'b1; bus.Burst = 1'b0;
        @(negedge SCLK);
        bus.Rd_req = 1'b0;
        @(negedge SCLK);
        bus.Rd_Valid = 1'b1; bus.Rd_Data = 8'hF0;
        first4 = '0;
        for (int b = 0; b < 4; b++) begin
            @(negedge SCLK);
            bus.Rd_Valid = 1'b0;
            first4 = {first4[2:0], bus.MISO};
        end
        chk("abort_first4", 32'(first4), 32'hF);
        #2 bus.SS = 1'b1;
        #1;
        chk("abort_clear", 32'({bus.MISO, bus.MISO_OE, bus.Rd_EN, bus.tx_tick}), 32'd0);
        chk("abort_addr", 32'(bus.Rd_Addr), 32'h55);
        @(negedge SCLK);
        chk("abort_hold", 32'({bus.MISO, bus.MISO_OE, bus.tx_tick}), 32'd0);
        bus.SS = 1'b0;
        xfer("restart", 8'h10, 1, 0, {8'h00, 8'h00, 8'h5A}, {8'h00, 8'h00, 8'h10}, 1'b0);

        for (int t = 0; t < 20; t++) begin
            ra   = 8'($urandom);
            rn   = $urandom_range(1, 3);
            rdly = $urandom_range(0, 4);
            for (int w = 0; w < 3; w++) begin
                rd[w]  = 8'($urandom);
                rea[w] = 8'((int'(ra) + w) % 256);
            end
            xfer($sformatf("rand%0d", t), ra, rn, rdly, rd, rea, 1'b1);
        end

        // Reset lands while bit 2 is on the line.
        @(negedge SCLK);
        bus.Address = 8'h77; bus.Rd_req = 1'b1; bus.Burst = 1'b0;
        @(negedge SCLK);
        bus.Rd_req = 1'b0;
        @(negedge SCLK);
        bus.Rd_Valid = 1'b1; bus.Rd_Data = 8'hC3;
        repeat (2) begin
            @(negedge SCLK);
            bus.Rd_Valid = 1'b0;
        end
        chk("pre_reset_addr", 32'(bus.Rd_Addr), 32'h77);
        #2 RST = 1'b0;
        #1;
        chk("reset_midshift", 32'({bus.Rd_EN, bus.Rd_Addr, bus.MISO, bus.MISO_OE, bus.tx_tick}), 32'd0);
        @(negedge SCLK);
        RST = 1'b1;

        bus.SS = 1'b1; bus.Address = 8'h99; bus.Rd_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge SCLK);
            chk("ss_high_ignore", 32'({bus.Rd_EN, bus.Rd_Addr}), 32'd0);
        end
        bus.Rd_req = 1'b0; bus.SS = 1'b0;
        xfer("recover", 8'hC8, 1, 1, {8'h00, 8'h00, 8'h96}, {8'h00, 8'h00, 8'hC8}, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_slave_read_tx.md
SPI_SLAVE_READ_TX -- requirements
Module: spi_slave_read_tx

Interface
REQ-001 Parameter: WIDTH, default 8, address/data bus width and bits per SPI word.
REQ-002 SCLK  input  1  serial clock; all sequential logic on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-low.
REQ-004 SS  input  1  slave select, active-low; high aborts any transfer.
REQ-005 Rd_req  input  1  one-cycle pulse from slave FSM: start read at Address.
REQ-006 Burst  input  1  high: continue with next address after each word.
REQ-007 Address  input  WIDTH  start address captured from the receive path.
REQ-008 Rd_Data  input  WIDTH  read data from the register file.
REQ-009 Rd_Valid  input  1  register file: Rd_Data valid this cycle.
REQ-010 Rd_EN  output  1  one-cycle read strobe to the register file.
REQ-011 Rd_Addr  output  WIDTH  read address to the register file.
REQ-012 MISO  output  1  serial data out, MSB first.
REQ-013 MISO_OE  output  1  MISO output enable; pad tri-states when low.
REQ-014 tx_tick  output  1  one-cycle pulse after the last bit of a word is sent.

Function
REQ-015 FSM states: IDLE, FETCH, WAIT, SHIFT (plus PARITY when configured, see REQ-028).
REQ-016 IDLE: on posedge with SS=0 and Rd_req=1 -> Rd_Addr<=Address, Rd_EN<=1, go FETCH; else hold and Rd_EN=0.
REQ-017 FETCH: lasts exactly one cycle; Rd_EN<=0, go WAIT.
REQ-018 WAIT: on posedge with Rd_Valid=1 -> shift register<=Rd_Data, MISO<=Rd_Data[WIDTH-1], MISO_OE<=1, bit counter<=0, go SHIFT.
REQ-019 WAIT: no timeout; holds until Rd_Valid=1 or SS=1.
REQ-020 SHIFT: each posedge with bit counter<WIDTH-1 -> MISO<=next lower bit, bit counter+1; each bit is held for exactly one SCLK period.
REQ-021 SHIFT at bit counter==WIDTH-1 with Burst=1 -> tx_tick<=1, Rd_Addr<=Rd_Addr+1 (modulo 2^WIDTH, so all-ones wraps to 0), Rd_EN<=1, MISO_OE<=0, go FETCH.
REQ-022 SHIFT at bit counter==WIDTH-1 with Burst=0 -> tx_tick<=1, MISO<=0, MISO_OE<=0, go IDLE.
REQ-023 Latency from the Rd_req posedge to the first MISO bit = 2 posedges plus the register-file wait; minimum is 3 posedges, with Rd_Valid high in the first WAIT cycle.
REQ-024 Rd_req outside IDLE is ignored, and Rd_Valid outside WAIT is ignored.
REQ-025 SS going high, asynchronously and in any state, forces IDLE and clears bit counter, MISO, MISO_OE, Rd_EN and tx_tick; Rd_Addr and the shift register are retained.
REQ-026 SS=1 while the clock runs: the FSM stays in IDLE, and Rd_req is ignored.

Reset
REQ-027 RST=0 asynchronously forces IDLE, with Rd_EN=0, Rd_Addr=0, MISO=0, MISO_OE=0, tx_tick=0, and bit counter and shift register at 0. RST has priority over SS.

Configuration
REQ-028 Macro SPI_TX_PARITY_EN defined: after bit 0 the FSM enters PARITY for one cycle, drives MISO with odd parity of the word (XOR of the data bits inverted), and then applies the REQ-021/REQ-022 actions; each word takes WIDTH+1 SCLK periods.
REQ-029 Macro SPI_TX_PARITY_EN undefined: there is no PARITY state, and each word takes exactly WIDTH periods.

Verification (WIDTH=8)
REQ-030 Single read: Address=0x3C, Rd_req pulse, Rd_Valid 1 cycle after FETCH with Rd_Data=0xA5 -> Rd_EN one pulse with Rd_Addr=0x3C; MISO bits 1,0,1,0,0,1,0,1 on consecutive posedges; tx_tick on the 8th; MISO_OE low afterwards.
REQ-031 Burst wrap: Address=0xFE, Burst=1, data 0x11/0x22/0x33 -> Rd_Addr 0xFE, 0xFF, 0x00; three words shifted; three tx_tick pulses.
REQ-032 Slow register file: Rd_Valid held off for 5 cycles -> FSM stays in WAIT, MISO_OE=0; the first bit appears the posedge after Rd_Valid.
REQ-033 Abort: SS high after the 4th bit of 0xF0 -> MISO=0 and MISO_OE=0 immediately, FSM in IDLE, Rd_Addr unchanged; a subsequent Rd_req restarts cleanly.
REQ-034 Reset mid-SHIFT: RST low at bit 2 -> all outputs 0 asynchronously, including Rd_Addr=0x00.
REQ-035 With SPI_TX_PARITY_EN defined: Rd_Data=0xA5 (four ones) -> 9th MISO bit is 1, and tx_tick is asserted after the 9th period.
